// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types and March C- element tables for the SRAM BIST engine
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    typedef enum logic [2:0] {
        ELEM_M0 = 3'd0,
        ELEM_M1 = 3'd1,
        ELEM_M2 = 3'd2,
        ELEM_M3 = 3'd3,
        ELEM_M4 = 3'd4,
        ELEM_M5 = 3'd5
    } march_elem_e;

    // Bit i of each table describes element Mi; "one" means the inverted background.
    localparam logic [7:0] ELEM_UP     = 8'b0000_0111;
    localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
    localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
    localparam logic [7:0] ELEM_RD_ONE = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_ONE = 8'b0000_1010;

    function automatic logic elem_flag(input logic [7:0] tbl, input march_elem_e e);
        return tbl[e];
    endfunction

endpackage

// File: rtl/sram_bist_rdpipe.sv
// rtl/sram_bist_rdpipe.sv - read-latency pipe carrying expected data, address and element of each read
module sram_bist_rdpipe
    import sram_bist_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_expected,
    input  logic [ADDR_SIZE-1:0] in_addr,
    input  march_elem_e          in_elem,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_expected,
    output logic [ADDR_SIZE-1:0] out_addr,
    output march_elem_e          out_elem,
    output logic                 pending
);

    logic [RD_LAT-1:0]    vld_q;
    logic [DATA_SIZE-1:0] exp_q  [RD_LAT];
    logic [ADDR_SIZE-1:0] addr_q [RD_LAT];
    march_elem_e          elem_q [RD_LAT];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
                elem_q[i] <= ELEM_M0;
            end
        end else begin
            vld_q[0]  <= in_valid && !flush;
            exp_q[0]  <= in_expected;
            addr_q[0] <= in_addr;
            elem_q[0] <= in_elem;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1] && !flush;
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
                elem_q[i] <= elem_q[i-1];
            end
        end
    end

    // Reads still travelling behind the stage being compared this cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pending = pending | vld_q[i];
        end
    end

    assign out_valid    = vld_q[RD_LAT-1];
    assign out_expected = exp_q[RD_LAT-1];
    assign out_addr     = addr_q[RD_LAT-1];
    assign out_elem     = elem_q[RD_LAT-1];

endmodule

// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - March C- BIST master for one selected macro on the shared SRAM port-0 bus
module sram_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int ADDR_SIZE  = 16,
    parameter int DATA_SIZE  = 32,
    parameter int WMASK_SIZE = 4,
    parameter int NUM_SRAMS  = 16,
    parameter int RD_LAT     = 1,
    parameter int ERR_W      = 16,
    localparam int SEL_W     = (NUM_SRAMS > 1) ? $clog2(NUM_SRAMS) : 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic                           abort,
    input  logic [SEL_W-1:0]               sram_sel,
    input  logic [ADDR_SIZE-1:0]           addr_max,
    input  logic [DATA_SIZE-1:0]           data_mask,
    input  logic [DATA_SIZE-1:0]           pattern,
    input  logic [NUM_SRAMS*DATA_SIZE-1:0] sram_dout,
    output logic [ADDR_SIZE-1:0]           addr0,
    output logic [DATA_SIZE-1:0]           din0,
    output logic                           web0,
    output logic [WMASK_SIZE-1:0]          wmask0,
    output logic [NUM_SRAMS-1:0]           csb0,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [ERR_W-1:0]               err_count,
    output logic [ADDR_SIZE-1:0]           fail_addr,
    output logic [2:0]                     fail_element,
    output logic [DATA_SIZE-1:0]           fail_data
);

    bist_state_e          state_q, state_d;
    march_elem_e          elem_q, elem_nxt, fail_elem_q;
    logic                 phase_q;
    logic [ADDR_SIZE-1:0] addr_q, addr_max_q, fail_addr_q;
    logic [SEL_W-1:0]     sel_q;
    logic [DATA_SIZE-1:0] mask_q, pattern_q, fail_data_q;
    logic [ERR_W-1:0]     err_q;

    logic                 op_active, op_read, op_write, bg_one;
    logic                 last_op_here, last_addr, last_op_all, start_ok, pipe_flush;
    logic [DATA_SIZE-1:0] op_data, dout_sel, cmp_diff;
    logic                 pipe_vld, pipe_pending, mismatch;
    logic [DATA_SIZE-1:0] pipe_exp;
    logic [ADDR_SIZE-1:0] pipe_addr;
    march_elem_e          pipe_elem;

    assign op_active    = (state_q == ST_RUN);
    assign op_read      = op_active && elem_flag(ELEM_HAS_RD, elem_q) && !phase_q;
    assign op_write     = op_active && !op_read;
    assign bg_one       = op_read ? elem_flag(ELEM_RD_ONE, elem_q) : elem_flag(ELEM_WR_ONE, elem_q);
    assign op_data      = bg_one ? ~pattern_q : pattern_q;
    assign last_op_here = phase_q || !(elem_flag(ELEM_HAS_RD, elem_q) && elem_flag(ELEM_HAS_WR, elem_q));
    assign last_addr    = elem_flag(ELEM_UP, elem_q) ? (addr_q == addr_max_q) : (addr_q == '0);
    assign last_op_all  = last_op_here && last_addr && (elem_q == ELEM_M5);
    assign elem_nxt     = march_elem_e'(elem_q + 3'd1);
    assign start_ok     = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign pipe_flush   = abort && (state_q == ST_RUN || state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)            state_d = ST_IDLE;
                else if (last_op_all) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)             state_d = ST_IDLE;
                else if (!pipe_pending) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Sequencer: phase steps r->w within an address, then address, then element.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            elem_q     <= ELEM_M0;
            phase_q    <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            addr_max_q <= '0;
            mask_q     <= '0;
            pattern_q  <= '0;
        end else if (start_ok) begin
            elem_q     <= ELEM_M0;
            phase_q    <= 1'b0;
            addr_q     <= '0;
            sel_q      <= sram_sel;
            addr_max_q <= addr_max;
            mask_q     <= data_mask;
            pattern_q  <= pattern;
        end else if (op_active && !abort) begin
            if (!last_op_here) begin
                phase_q <= 1'b1;
            end else begin
                phase_q <= 1'b0;
                if (!last_addr) begin
                    addr_q <= elem_flag(ELEM_UP, elem_q) ? addr_q + ADDR_SIZE'(1) : addr_q - ADDR_SIZE'(1);
                end else if (elem_q != ELEM_M5) begin
                    elem_q <= elem_nxt;
                    addr_q <= elem_flag(ELEM_UP, elem_nxt) ? '0 : addr_max_q;
                end
            end
        end
    end

    sram_bist_rdpipe #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE),
        .RD_LAT    (RD_LAT)
    ) u_rdpipe (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (pipe_flush),
        .in_valid     (op_read),
        .in_expected  (op_data),
        .in_addr      (addr_q),
        .in_elem      (elem_q),
        .out_valid    (pipe_vld),
        .out_expected (pipe_exp),
        .out_addr     (pipe_addr),
        .out_elem     (pipe_elem),
        .pending      (pipe_pending)
    );

    always_comb begin
        dout_sel = '0;
        for (int i = 0; i < NUM_SRAMS; i++) begin
            if (sel_q == SEL_W'(i)) dout_sel = sram_dout[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    assign cmp_diff = (dout_sel ^ pipe_exp) & mask_q;
    assign mismatch = pipe_vld && (cmp_diff != '0);

    // err_q == 0 doubles as "no mismatch yet", since the counter never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= ELEM_M0;
            fail_data_q <= '0;
        end else if (start_ok) begin
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= ELEM_M0;
            fail_data_q <= '0;
        end else if (mismatch) begin
            if (err_q != '1) err_q <= err_q + ERR_W'(1);
            if (err_q == '0) begin
                fail_addr_q <= pipe_addr;
                fail_elem_q <= pipe_elem;
                fail_data_q <= cmp_diff;
            end
        end
    end

    always_comb begin
        csb0 = '1;
        for (int i = 0; i < NUM_SRAMS; i++) begin
            if (op_active && sel_q == SEL_W'(i)) csb0[i] = 1'b0;
        end
    end

    assign addr0        = op_active ? addr_q : '0;
    assign din0         = op_write ? op_data : '0;
    assign web0         = !op_write;
    assign wmask0       = op_write ? '1 : '0;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign pass         = done && (err_q == '0);
    assign err_count    = err_q;
    assign fail_addr    = fail_addr_q;
    assign fail_element = fail_elem_q;
    assign fail_data    = fail_data_q;

endmodule
